// File: rtl/pmips_dmem_responder.sv
// PMIPS data-memory responder: word RAM plus an IO page holding a
// console TX FIFO, a cycle timer, status and drop counters.
//
// Ports:
//   clock, reset      system clock; synchronous active-high reset
//   dmemaddr          byte address from the core MEM stage
//   dmemwdata         write data
//   dmemwrite         write enable, sampled at posedge
//   dmemread          read enable
//   dmemrdata         combinational read data (0 when dmemread=0)
//   tx_data/tx_valid  console FIFO head and non-empty flag
//   tx_ready          sink accepts the head at posedge
//   err_misaligned    sticky odd-address access flag
//
// Optional feature: define PMIPS_DMEM_TIMER_EN to build the TIMER
// register at FF04; otherwise FF04 reads 0 and ignores writes.

module pmips_dmem_responder #(
  parameter int ADDR_BITS  = 7,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] dmemaddr,
  input  logic [15:0] dmemwdata,
  input  logic        dmemwrite,
  input  logic        dmemread,
  output logic [15:0] dmemrdata,
  output logic [15:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        err_misaligned
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int RAM_WORDS = 2 ** ADDR_BITS;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  // ------------------------------------------------------------
  // Address decode
  // ------------------------------------------------------------
  logic                 io_sel;
  logic                 mis;
  logic [ADDR_BITS-1:0] widx;
  logic                 sel_con;
  logic                 sel_sta;
  logic                 sel_tmr;
  logic                 sel_drp;

  assign io_sel  = (dmemaddr[15:8] == 8'hFF);
  assign mis     = dmemaddr[0];
  assign widx    = dmemaddr[ADDR_BITS:1];
  assign sel_con = io_sel && (dmemaddr[7:0] == 8'h00);
  assign sel_sta = io_sel && (dmemaddr[7:0] == 8'h02);
  assign sel_tmr = io_sel && (dmemaddr[7:0] == 8'h04);
  assign sel_drp = io_sel && (dmemaddr[7:0] == 8'h06);

  // Aligned write strobes; an odd address never matches an IO
  // register, but the RAM strobe needs the explicit qualifier.
  logic wr_ok;
  logic wr_ram;
  logic wr_con;
  logic wr_sta;
  logic wr_drp;

  assign wr_ok  = dmemwrite && !mis;
  assign wr_ram = wr_ok && !io_sel;
  assign wr_con = wr_ok && sel_con;
  assign wr_sta = wr_ok && sel_sta;
  assign wr_drp = wr_ok && sel_drp;

  // ------------------------------------------------------------
  // Word RAM (not reset; zero at time 0 in simulation)
  // ------------------------------------------------------------
  logic [15:0] ram [RAM_WORDS] = '{default: '0};

  // A RAM write completes even while reset is asserted.
  always_ff @(posedge clock) begin
    if (wr_ram) begin
      ram[widx] <= dmemwdata;
    end
  end

  // ------------------------------------------------------------
  // Console TX FIFO
  // ------------------------------------------------------------
  logic [15:0]   fifo [FIFO_DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic [CW-1:0] cnt;
  logic          full;
  logic          empty;
  logic          pop;
  logic          push_ok;
  logic          drop;

  assign empty = (cnt == '0);
  assign full  = (cnt == FULL_CNT);
  assign pop   = tx_valid && tx_ready;

  // A full FIFO still accepts a push when the head leaves on
  // the same edge.
  assign push_ok = wr_con && (!full || pop);
  assign drop    = wr_con && !push_ok;

  assign tx_valid = !empty;
  assign tx_data  = empty ? 16'h0000 : fifo[rp];

  always_ff @(posedge clock) begin
    if (!reset && push_ok) begin
      fifo[wp] <= dmemwdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push_ok) begin
        wp <= wp + 1'b1;
      end
      if (pop) begin
        rp <= rp + 1'b1;
      end
      unique case ({push_ok, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // ------------------------------------------------------------
  // DROPS counter, saturating
  // ------------------------------------------------------------
  logic [15:0] drops;

  always_ff @(posedge clock) begin
    if (reset) begin
      drops <= '0;
    end else if (wr_drp) begin
      drops <= '0;
    end else if (drop && (drops != 16'hFFFF)) begin
      drops <= drops + 16'd1;
    end
  end

  // ------------------------------------------------------------
  // Sticky misaligned flag; a new misaligned access beats a
  // STATUS clear.
  // ------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      err_misaligned <= 1'b0;
    end else if ((dmemread || dmemwrite) && mis) begin
      err_misaligned <= 1'b1;
    end else if (wr_sta) begin
      err_misaligned <= 1'b0;
    end
  end

  // ------------------------------------------------------------
  // Cycle timer
  // ------------------------------------------------------------
  logic [15:0] timer_q;

`ifdef PMIPS_DMEM_TIMER_EN
  logic wr_tmr;

  assign wr_tmr = wr_ok && sel_tmr;

  always_ff @(posedge clock) begin
    if (reset) begin
      timer_q <= '0;
    end else if (wr_tmr) begin
      timer_q <= dmemwdata;
    end else begin
      timer_q <= timer_q + 16'd1;
    end
  end
`else
  assign timer_q = 16'h0000;
`endif

  // ------------------------------------------------------------
  // Read mux; a simultaneous write shows the pre-edge value
  // because every source is a register read before the edge.
  // ------------------------------------------------------------
  logic [15:0] status;

  assign status = {13'b0, err_misaligned, full, empty};

  always_comb begin
    dmemrdata = 16'h0000;
    if (dmemread && !mis) begin
      unique case (1'b1)
        !io_sel: dmemrdata = ram[widx];
        sel_con: dmemrdata = 16'(cnt);
        sel_sta: dmemrdata = status;
        sel_tmr: dmemrdata = timer_q;
        sel_drp: dmemrdata = drops;
        default: dmemrdata = 16'h0000;
      endcase
    end
  end

endmodule
